// File: rtl/ddc_ctl.sv
// Control and sequencing for the 14-bit decimating downconverter: host register file,
// reset/settle sequencing with output blanking, and a peak/saturation-driven block AGC.
module ddc_ctl #(
  parameter int FSZ      = 26,
  parameter int OSZ      = 16,
  parameter int RST_CYC  = 4,
  parameter int SETTLE_N = 16,
  parameter int AGC_WIN  = 256,
  parameter int HI_THR   = 24576,
  parameter int LO_THR   = 6144
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cfg_we,
  input  logic [1:0]     cfg_addr,
  input  logic [31:0]    cfg_wdat,
  output logic           ddc_reset,
  output logic [FSZ-1:0] frq,
  output logic [1:0]     dr,
  output logic [3:0]     cic_shf,
  output logic           ns_ena,
  input  logic [6:0]     sathld,
  input  logic           ddc_valid,
  input  logic [OSZ-1:0] ddc_i,
  input  logic [OSZ-1:0] ddc_q,
  output logic           out_valid,
  output logic [OSZ-1:0] out_i,
  output logic [OSZ-1:0] out_q,
  output logic           busy,
  output logic           agc_step
);

  localparam int CMAX = (RST_CYC > SETTLE_N) ? RST_CYC : SETTLE_N;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int WW   = (AGC_WIN > 1) ? $clog2(AGC_WIN) : 1;

  localparam logic [CW-1:0]  RST_LAST    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_N - 1);
  localparam logic [WW-1:0]  WIN_LAST    = WW'(AGC_WIN - 1);
  localparam logic [OSZ-1:0] HI_LVL      = OSZ'(HI_THR);
  localparam logic [OSZ-1:0] LO_LVL      = OSZ'(LO_THR);

  typedef enum logic [1:0] {ST_RST, ST_SETTLE, ST_RUN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [FSZ-1:0] frq_q, frq_d;
  logic [1:0]     dr_q, dr_d;
  logic [3:0]     shf_q, shf_d;
  logic           ns_q, ns_d;
  logic           agc_en_q, agc_en_d;
  logic           ov_q, ov_d;
  logic [OSZ-1:0] oi_q, oi_d, oq_q, oq_d;
  logic           step_q, step_d;
  logic [WW-1:0]  win_q, win_d;
  logic [OSZ-1:0] peak_q, peak_d;
  logic           sat_q, sat_d;

  logic [OSZ-1:0] mag_i, mag_q, pk_max;
  logic           cfg_rst, cfg_settle, sat_now;
  logic           unused_wdat;

  assign unused_wdat = ^cfg_wdat[31:FSZ];

  // Magnitude with the most negative code saturated so it fits the positive range.
  function automatic logic [OSZ-1:0] mag(input logic [OSZ-1:0] x);
    logic [OSZ-1:0] neg;
    neg = ~x + 1'b1;
    if (!x[OSZ-1])                             return x;
    else if (x == {1'b1, {(OSZ-1){1'b0}}})     return {1'b0, {(OSZ-1){1'b1}}};
    else                                       return neg;
  endfunction

  always_comb begin
    mag_i  = mag(ddc_i);
    mag_q  = mag(ddc_q);
    pk_max = peak_q;
    if (mag_i > pk_max) pk_max = mag_i;
    if (mag_q > pk_max) pk_max = mag_q;
    sat_now = sat_q | (|sathld);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    frq_d      = frq_q;
    dr_d       = dr_q;
    shf_d      = shf_q;
    ns_d       = ns_q;
    agc_en_d   = agc_en_q;
    ov_d       = 1'b0;
    oi_d       = oi_q;
    oq_d       = oq_q;
    step_d     = 1'b0;
    win_d      = win_q;
    peak_d     = peak_q;
    sat_d      = sat_q;
    cfg_rst    = 1'b0;
    cfg_settle = 1'b0;

    // The AGC window only accumulates while running with AGC on; holding it clear
    // otherwise covers RST/SETTLE entry and the enable's 0->1 edge.
    if (state_q != ST_RUN || !agc_en_q) begin
      win_d  = '0;
      peak_d = '0;
      sat_d  = 1'b0;
    end

    if (cfg_we) begin
      case (cfg_addr)
        2'd0: begin
          frq_d      = cfg_wdat[FSZ-1:0];
          cfg_settle = (state_q != ST_RST);
        end
        2'd1: begin
          dr_d    = cfg_wdat[1:0];
          cfg_rst = 1'b1;
        end
        2'd2: begin
          shf_d      = cfg_wdat[3:0];
          cfg_settle = (state_q != ST_RST);
        end
        default: begin
          ns_d     = cfg_wdat[0];
          agc_en_d = cfg_wdat[1];
        end
      endcase
    end

    if (cfg_rst) begin
      state_d = ST_RST;
      cnt_d   = '0;
    end else if (cfg_settle) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (ddc_valid) begin
            if (cnt_q == SETTLE_LAST) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          if (ddc_valid) begin
            ov_d = 1'b1;
            oi_d = ddc_i;
            oq_d = ddc_q;
          end
          if (agc_en_q) begin
            sat_d = sat_now;
            if (ddc_valid) begin
              peak_d = pk_max;
              win_d  = win_q + 1'b1;
              if (win_q == WIN_LAST) begin
                win_d  = '0;
                peak_d = '0;
                sat_d  = 1'b0;
                // A concurrent register write (CTRL here) pre-empts the gain decision.
                if (!cfg_we) begin
                  if (sat_now || pk_max >= HI_LVL) begin
                    if (shf_q != 4'd0) begin
                      shf_d  = shf_q - 1'b1;
                      step_d = 1'b1;
                    end
                  end else if (pk_max < LO_LVL) begin
                    if (shf_q != 4'hF) begin
                      shf_d  = shf_q + 1'b1;
                      step_d = 1'b1;
                    end
                  end
                  if (step_d) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                  end
                end
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_RST;
      cnt_q    <= '0;
      frq_q    <= '0;
      dr_q     <= '0;
      shf_q    <= '0;
      ns_q     <= 1'b0;
      agc_en_q <= 1'b0;
      ov_q     <= 1'b0;
      oi_q     <= '0;
      oq_q     <= '0;
      step_q   <= 1'b0;
      win_q    <= '0;
      peak_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frq_q    <= frq_d;
      dr_q     <= dr_d;
      shf_q    <= shf_d;
      ns_q     <= ns_d;
      agc_en_q <= agc_en_d;
      ov_q     <= ov_d;
      oi_q     <= oi_d;
      oq_q     <= oq_d;
      step_q   <= step_d;
      win_q    <= win_d;
      peak_q   <= peak_d;
      sat_q    <= sat_d;
    end
  end

  assign ddc_reset = (state_q == ST_RST);
  assign busy      = (state_q != ST_RUN);
  assign frq       = frq_q;
  assign dr        = dr_q;
  assign cic_shf   = shf_q;
  assign ns_ena    = ns_q;
  assign out_valid = ov_q;
  assign out_i     = oi_q;
  assign out_q     = oq_q;
  assign agc_step  = step_q;

endmodule
